traffic_light_monitor: RTL and testbench

TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

---
 rtl/traffic_pkg.sv | 47 ++++
 rtl/dwell_timer.sv | 60 ++++++
 rtl/traffic_light_monitor.sv | 167 ++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light monitor: lamp phase codes and FSM state types.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Phase codes match the controller: RED=00, GREEN=01, YELLOW=10.
package traffic_pkg;

   localparam logic [1:0] PH_RED    = 2'b00;
   localparam logic [1:0] PH_GREEN  = 2'b01;
   localparam logic [1:0] PH_YELLOW = 2'b10;

   typedef enum logic [1:0] {
      ST_SYNC,
      ST_RED,
      ST_GREEN,
      ST_YELLOW
   } state_e;

   // How far the current RED->GREEN->YELLOW cycle has progressed without any error.
   typedef enum logic [1:0] {
      ARM_NONE,
      ARM_RED,
      ARM_GREEN,
      ARM_YELLOW
   } arm_e;

   function automatic logic [1:0] state_phase(input state_e s);
      logic [1:0] p;
      case (s)
         ST_GREEN:  p = PH_GREEN;
         ST_YELLOW: p = PH_YELLOW;
         default:   p = PH_RED;
      endcase
      return p;
   endfunction

   function automatic state_e succ_state(input state_e s);
      state_e n;
      case (s)
         ST_RED:    n = ST_GREEN;
         ST_GREEN:  n = ST_YELLOW;
         ST_YELLOW: n = ST_RED;
         default:   n = ST_SYNC;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter for one lamp phase, saturating at 255, with min/max legality compares.
// Latency: under_min_o is combinational from the count; over_max_o is combinational from hold_i.
// Backpressure: none.
// Ports: clk_i, rst_i (sync, active-high); clear_i (drop to 0), enter_i (load 1), hold_i (count up);
//        under_min_o (count below MIN_DWELL), over_max_o (this hold pushes past MAX_DWELL, once per occupancy).
module dwell_timer #(
   parameter int unsigned MIN_DWELL = 1,
   parameter int unsigned MAX_DWELL = 1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic enter_i,
   input  logic hold_i,
   output logic under_min_o,
   output logic over_max_o
);

   localparam logic [7:0] MIN_C = 8'(MIN_DWELL);
   localparam logic [7:0] MAX_C = 8'(MAX_DWELL);

   logic [7:0] dwell_q, dwell_d;
   // Remembers that the max violation already fired, so a count pinned at
   // saturation does not report again every cycle.
   logic       fired_q, fired_d;

   always_comb begin
      dwell_d    = dwell_q;
      fired_d    = fired_q;
      over_max_o = 1'b0;
      if (clear_i) begin
         dwell_d = 8'd0;
         fired_d = 1'b0;
      end else if (enter_i) begin
         dwell_d = 8'd1;
         fired_d = 1'b0;
      end else if (hold_i) begin
         if (dwell_q == MAX_C && !fired_q) begin
            over_max_o = 1'b1;
            fired_d    = 1'b1;
         end
         if (dwell_q != 8'hFF) begin
            dwell_d = dwell_q + 8'd1;
         end
      end
   end

   assign under_min_o = (dwell_q < MIN_C);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         dwell_q <= 8'd0;
         fired_q <= 1'b0;
      end else begin
         dwell_q <= dwell_d;
         fired_q <= fired_d;
      end
   end

endmodule

// File: rtl/traffic_light_monitor.sv
// Watches red/yellow/green lamp drives, tracks the phase and flags code, order and timing faults.
// Latency: all outputs registered; they reflect the sample taken on the previous rising edge.
// Backpressure: none; one lamp sample consumed every cycle.
// Ports: clk, rst (sync, active-high); red/yellow/green lamp samples; err_clr clears sticky flags;
//        phase/phase_valid tracked phase; err_onehot/err_seq/err_dwell/err_any sticky flags;
//        cycle_count completed clean RED->GREEN->YELLOW->RED cycles (wraps).
module traffic_light_monitor
   import traffic_pkg::*;
#(
   parameter int unsigned MIN_DWELL = 1,
   parameter int unsigned MAX_DWELL = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        red,
   input  logic        yellow,
   input  logic        green,
   input  logic        err_clr,
   output logic [1:0]  phase,
   output logic        phase_valid,
   output logic        err_onehot,
   output logic        err_seq,
   output logic        err_dwell,
   output logic        err_any,
   output logic [15:0] cycle_count
);

   state_e      state_q, state_d;
   arm_e        arm_q, arm_d;
   logic [1:0]  phase_q;
   logic        phase_valid_q;
   logic        err_onehot_q, err_onehot_d;
   logic        err_seq_q, err_seq_d;
   logic        err_dwell_q, err_dwell_d;
   logic        err_any_q;
   logic [15:0] count_q, count_d;

   logic [1:0]  lamp_cnt;
   logic        legal, dark;
   state_e      obs_state;

   logic        t_clear, t_enter, t_hold, change;
   logic        new_onehot, new_seq, new_dwell, err_now;
   logic        under_min, over_max;

   assign lamp_cnt  = {1'b0, red} + {1'b0, yellow} + {1'b0, green};
   assign legal     = (lamp_cnt == 2'd1);
   assign dark      = (lamp_cnt == 2'd0);
   assign obs_state = red ? ST_RED : (green ? ST_GREEN : ST_YELLOW);

   dwell_timer #(
      .MIN_DWELL (MIN_DWELL),
      .MAX_DWELL (MAX_DWELL)
   ) u_dwell (
      .clk_i       (clk),
      .rst_i       (rst),
      .clear_i     (t_clear),
      .enter_i     (t_enter),
      .hold_i      (t_hold),
      .under_min_o (under_min),
      .over_max_o  (over_max)
   );

   // Phase tracking FSM.
   always_comb begin
      state_d    = state_q;
      new_onehot = 1'b0;
      new_seq    = 1'b0;
      t_clear    = 1'b0;
      t_enter    = 1'b0;
      t_hold     = 1'b0;
      change     = 1'b0;
      case (state_q)
         ST_SYNC: begin
            if (legal) begin
               state_d = obs_state;
               t_enter = 1'b1;
            end else if (!dark) begin
               new_onehot = 1'b1;
            end
         end
         default: begin
            if (!legal) begin
               new_onehot = 1'b1;
               state_d    = ST_SYNC;
               t_clear    = 1'b1;
            end else if (obs_state == state_q) begin
               t_hold = 1'b1;
            end else begin
               // Any legal change re-locks on the observed phase; only the
               // natural successor is in order.
               state_d = obs_state;
               t_enter = 1'b1;
               change  = 1'b1;
               if (obs_state != succ_state(state_q)) begin
                  new_seq = 1'b1;
               end
            end
         end
      endcase
   end

   assign new_dwell = (change && under_min) || over_max;
   assign err_now   = new_onehot || new_seq || new_dwell;

   // Cycle progress: a cycle counts only if every step from the opening RED
   // onward (including the closing YELLOW->RED) was clean.
   always_comb begin
      arm_d   = arm_q;
      count_d = count_q;
      if (err_now) begin
         arm_d = ARM_NONE;
      end else if (t_enter) begin
         case (state_d)
            ST_RED: begin
               if (arm_q == ARM_YELLOW) begin
                  count_d = count_q + 16'd1;
               end
               arm_d = ARM_RED;
            end
            ST_GREEN:  arm_d = (arm_q == ARM_RED)   ? ARM_GREEN  : ARM_NONE;
            ST_YELLOW: arm_d = (arm_q == ARM_GREEN) ? ARM_YELLOW : ARM_NONE;
            default:   arm_d = ARM_NONE;
         endcase
      end
   end

   // Sticky flags: a new error wins over a simultaneous clear.
   always_comb begin
      err_onehot_d = (err_onehot_q && !err_clr) || new_onehot;
      err_seq_d    = (err_seq_q    && !err_clr) || new_seq;
      err_dwell_d  = (err_dwell_q  && !err_clr) || new_dwell;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_SYNC;
         arm_q         <= ARM_NONE;
         phase_q       <= PH_RED;
         phase_valid_q <= 1'b0;
         err_onehot_q  <= 1'b0;
         err_seq_q     <= 1'b0;
         err_dwell_q   <= 1'b0;
         err_any_q     <= 1'b0;
         count_q       <= 16'd0;
      end else begin
         state_q       <= state_d;
         arm_q         <= arm_d;
         phase_q       <= state_phase(state_d);
         phase_valid_q <= (state_d != ST_SYNC);
         err_onehot_q  <= err_onehot_d;
         err_seq_q     <= err_seq_d;
         err_dwell_q   <= err_dwell_d;
         err_any_q     <= err_onehot_d || err_seq_d || err_dwell_d;
         count_q       <= count_d;
      end
   end

   assign phase       = phase_q;
   assign phase_valid = phase_valid_q;
   assign err_onehot  = err_onehot_q;
   assign err_seq     = err_seq_q;
   assign err_dwell   = err_dwell_q;
   assign err_any     = err_any_q;
   assign cycle_count = count_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: two instances (default dwell limits and MIN=2/MAX=3) share one stimulus.
// Latency: a model updated on each rising edge predicts the registered outputs, compared on the falling edge.
// Backpressure: n/a.
module tb_traffic_light_monitor;

   logic clk = 1'b0;
   logic rst, red, yellow, green, err_clr;

   logic [1:0]  a_phase, b_phase;
   logic        a_valid, b_valid;
   logic        a_eo, a_es, a_ed, a_any;
   logic        b_eo, b_es, b_ed, b_any;
   logic [15:0] a_cnt, b_cnt;

   always #5 clk = ~clk;

   traffic_light_monitor dut_a (
      .clk (clk), .rst (rst), .red (red), .yellow (yellow), .green (green), .err_clr (err_clr),
      .phase (a_phase), .phase_valid (a_valid), .err_onehot (a_eo), .err_seq (a_es),
      .err_dwell (a_ed), .err_any (a_any), .cycle_count (a_cnt)
   );

   traffic_light_monitor #(.MIN_DWELL (2), .MAX_DWELL (3)) dut_b (
      .clk (clk), .rst (rst), .red (red), .yellow (yellow), .green (green), .err_clr (err_clr),
      .phase (b_phase), .phase_valid (b_valid), .err_onehot (b_eo), .err_seq (b_es),
      .err_dwell (b_ed), .err_any (b_any), .cycle_count (b_cnt)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // ---------------- behavioural model ----------------
   // Tracked phase: -1 = not locked, 0 = RED, 1 = GREEN, 2 = YELLOW.
   int    m_trk   [2];
   int    m_dwell [2];
   int    m_cnt   [2];
   bit    m_fired [2];
   bit    m_eo [2], m_es [2], m_ed [2];
   // Phases entered cleanly since the last clean RED, e.g. "RGY".
   string m_hist  [2];
   bit    started = 1'b0;

   function automatic int min_of(input int k); return (k == 0) ? 1 : 2; endfunction
   function automatic int max_of(input int k); return (k == 0) ? 1 : 3; endfunction

   task automatic model_step(input int k, input bit rs, input bit r, input bit y, input bit g, input bit c);
      int n, p;
      bit no, ns, nd, entered;
      string s;
      if (rs) begin
         m_trk[k] = -1; m_dwell[k] = 0; m_cnt[k] = 0; m_fired[k] = 0;
         m_eo[k] = 0; m_es[k] = 0; m_ed[k] = 0; m_hist[k] = "";
         return;
      end
      n = int'(r) + int'(y) + int'(g);
      no = 0; ns = 0; nd = 0; entered = 0; p = -1;
      if (n == 1) begin
         p = r ? 0 : (g ? 1 : 2);
         if (m_trk[k] < 0) begin
            entered = 1;
         end else if (p == m_trk[k]) begin
            if (m_dwell[k] == max_of(k) && !m_fired[k]) begin
               nd = 1;
               m_fired[k] = 1;
            end
            if (m_dwell[k] < 255) m_dwell[k]++;
         end else begin
            if (m_dwell[k] < min_of(k)) nd = 1;
            if (p != (m_trk[k] + 1) % 3) ns = 1;
            entered = 1;
         end
         if (entered) begin
            m_trk[k] = p; m_dwell[k] = 1; m_fired[k] = 0;
         end
      end else if (n > 1 || m_trk[k] >= 0) begin
         no = 1; m_trk[k] = -1; m_dwell[k] = 0; m_fired[k] = 0;
      end
      if (no || ns || nd) begin
         m_hist[k] = "";
      end else if (entered) begin
         if (p == 0) begin
            if (m_hist[k] == "RGY") m_cnt[k] = (m_cnt[k] + 1) % 65536;
            m_hist[k] = "R";
         end else if (m_hist[k] != "") begin
            s = (p == 1) ? "G" : "Y";
            m_hist[k] = {m_hist[k], s};
         end
      end
      m_eo[k] = (m_eo[k] && !c) || no;
      m_es[k] = (m_es[k] && !c) || ns;
      m_ed[k] = (m_ed[k] && !c) || nd;
   endtask

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) model_step(k, rst, red, yellow, green, err_clr);
      started = 1'b1;
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (started) begin
         chk("a_phase", int'(a_phase), (m_trk[0] < 0) ? 0 : m_trk[0]);
         chk("a_valid", int'(a_valid), int'(m_trk[0] >= 0));
         chk("a_err_onehot", int'(a_eo), int'(m_eo[0]));
         chk("a_err_seq", int'(a_es), int'(m_es[0]));
         chk("a_err_dwell", int'(a_ed), int'(m_ed[0]));
         chk("a_err_any", int'(a_any), int'(m_eo[0] || m_es[0] || m_ed[0]));
         chk("a_cycle_count", int'(a_cnt), m_cnt[0]);
         chk("b_phase", int'(b_phase), (m_trk[1] < 0) ? 0 : m_trk[1]);
         chk("b_valid", int'(b_valid), int'(m_trk[1] >= 0));
         chk("b_err_onehot", int'(b_eo), int'(m_eo[1]));
         chk("b_err_seq", int'(b_es), int'(m_es[1]));
         chk("b_err_dwell", int'(b_ed), int'(m_ed[1]));
         chk("b_err_any", int'(b_any), int'(m_eo[1] || m_es[1] || m_ed[1]));
         chk("b_cycle_count", int'(b_cnt), m_cnt[1]);
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input bit rr, input bit r, input bit y, input bit g, input bit c);
      rst = rr; red = r; yellow = y; green = g; err_clr = c;
      @(posedge clk);
      #2;
   endtask

   // p: 0 = RED, 1 = GREEN, 2 = YELLOW
   task automatic lamp(input int p, input bit c);
      cyc(1'b0, p == 0, p == 2, p == 1, c);
   endtask

   initial begin
      int cur;
      int sel;

      // Reset
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      chk("lit_rst_valid", int'(a_valid), 0);
      chk("lit_rst_phase", int'(a_phase), 0);
      chk("lit_rst_cnt", int'(a_cnt), 0);
      chk("lit_rst_any", int'(a_any), 0);

      // R,G,Y,R,G,Y,R one cycle each
      lamp(0, 0);
      chk("lit_lock_valid", int'(a_valid), 1);
      lamp(1, 0); lamp(2, 0); lamp(0, 0); lamp(1, 0); lamp(2, 0); lamp(0, 0);
      chk("lit_two_cycles", int'(a_cnt), 2);
      chk("lit_two_cycles_any", int'(a_any), 0);
      chk("lit_two_cycles_phase", int'(a_phase), 0);

      // Dark after reset, then RED
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
      chk("lit_dark_valid", int'(a_valid), 0);
      chk("lit_dark_any", int'(a_any), 0);
      lamp(0, 0);
      chk("lit_relock_valid", int'(a_valid), 1);
      chk("lit_relock_any", int'(a_any), 0);

      // GREEN -> RED is out of order; the resync RED does not open a countable cycle
      lamp(1, 0);
      lamp(0, 0);
      chk("lit_seq_err", int'(a_es), 1);
      chk("lit_seq_phase", int'(a_phase), 0);
      lamp(1, 0); lamp(2, 0); lamp(0, 0);
      chk("lit_seq_cnt", int'(a_cnt), 0);
      lamp(1, 0); lamp(2, 0); lamp(0, 0);
      chk("lit_after_cnt", int'(a_cnt), 1);

      // Clear on a clean step
      lamp(1, 1);
      chk("lit_clr_any", int'(a_any), 0);

      // Two lamps lit together
      cyc(0, 1, 0, 1, 0);
      chk("lit_ill_onehot", int'(a_eo), 1);
      chk("lit_ill_any", int'(a_any), 1);
      chk("lit_ill_valid", int'(a_valid), 0);
      lamp(2, 0);
      chk("lit_ill_relock_phase", int'(a_phase), 2);
      chk("lit_ill_sticky", int'(a_eo), 1);
      lamp(0, 0);

      // Clear coinciding with an out-of-order step: new error wins
      lamp(2, 1);
      chk("lit_setwins_seq", int'(a_es), 1);
      chk("lit_setwins_onehot", int'(a_eo), 0);
      lamp(0, 1);
      chk("lit_clr2_any", int'(a_any), 0);

      // Dwell limits on the MIN=2/MAX=3 instance
      cyc(1, 0, 0, 0, 0);
      lamp(0, 0); lamp(1, 0);
      chk("lit_b_min_dwell", int'(b_ed), 1);
      cyc(1, 0, 0, 0, 0);
      lamp(0, 0); lamp(0, 0); lamp(0, 0);
      chk("lit_b_max_early", int'(b_ed), 0);
      lamp(0, 0);
      chk("lit_b_max_dwell", int'(b_ed), 1);
      lamp(0, 1);
      chk("lit_b_max_once", int'(b_ed), 0);

      // Mixed tail, mostly legal progressions with some repeats and faults
      cur = 0;
      for (int i = 0; i < 400; i++) begin
         sel = $urandom_range(0, 19);
         if (sel < 11) begin
            cur = (cur + 1) % 3;
            lamp(cur, $urandom_range(0, 15) == 0);
         end else if (sel < 15) begin
            lamp(cur, $urandom_range(0, 15) == 0);
         end else if (sel < 17) begin
            cur = $urandom_range(0, 2);
            lamp(cur, $urandom_range(0, 7) == 0);
         end else if (sel < 19) begin
            cyc(0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
         end else begin
            cyc(1, 0, 0, 0, 0);
         end
      end

      @(posedge clk);
      #2;
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
